// File: rtl/lcd_display_ctrl_pkg.sv
// Shared types, LCD command bytes and character helpers
// for the 16x2 LCD sequencer.
package lcd_display_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SUB  = 3'd3,
        OP_SUBI = 3'd4,
        OP_MUL  = 3'd5,
        OP_CLR  = 3'd6,
        OP_DPL  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SHOW,
        S_BLANK
    } ctrl_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_WAIT
    } wr_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ROW1     = 8'h80;
    localparam logic [7:0] LCD_ROW2     = 8'hC0;

    localparam logic [4:0] INIT_LEN  = 5'd4;
    localparam logic [4:0] SHOW_LEN  = 5'd16;
    localparam logic [4:0] BLANK_LEN = 5'd1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] mnem_char(
        input logic [2:0] op,
        input logic [1:0] pos
    );
        logic [31:0] s;
        logic [7:0]  c;
        s = "DPL ";
        unique case (op)
            OP_LOAD: s = "LOAD";
            OP_ADD:  s = "ADD ";
            OP_ADDI: s = "ADDI";
            OP_SUB:  s = "SUB ";
            OP_SUBI: s = "SUBI";
            OP_MUL:  s = "MUL ";
            OP_CLR:  s = "CLR ";
            OP_DPL:  s = "DPL ";
            default: s = "DPL ";
        endcase
        unique case (pos)
            2'd0:    c = s[31:24];
            2'd1:    c = s[23:16];
            2'd2:    c = s[15:8];
            default: c = s[7:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_display_ctrl_byte_writer.sv
// One LCD byte transfer: setup cycle, enable pulse,
// then the command settle wait (longer after clear).
module lcd_byte_writer
    import lcd_display_ctrl_pkg::*;
#(
    parameter int CMD_CYC      = 2000,
    parameter int CLEAR_CYC    = 82000,
    parameter int EN_PULSE_CYC = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] din,
    output logic       ack,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int M1   = (CMD_CYC > CLEAR_CYC) ? CMD_CYC : CLEAR_CYC;
    localparam int MAXC = (M1 > EN_PULSE_CYC) ? M1 : EN_PULSE_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] EN_LAST  = CW'(EN_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYC - 1);

    wr_state_e     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_last;

    assign wait_last = (!lcd_rs && lcd_data == LCD_CLEAR)
                     ? CLR_LAST : CMD_LAST;
    assign done = (state == W_WAIT) && (cnt == wait_last);
    // next byte may be taken back-to-back in the final wait cycle
    assign ack  = req && ((state == W_IDLE) || done);

    // transfer timing; rs/data only load while lcd_e is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= W_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            unique case (state)
                W_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt == EN_LAST) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        state <= W_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                W_WAIT: begin
                    if (done) begin
                        cnt   <= '0;
                        state <= W_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= W_IDLE;
            endcase
            if (ack) begin
                lcd_rs   <= rs;
                lcd_data <= din;
                state    <= W_SETUP;
            end
        end
    end

endmodule

// File: rtl/lcd_display_ctrl.sv
// LCD sequencer: power-up wait, init commands, then
// instruction/result frames or a clear on request.
module lcd_display_ctrl
    import lcd_display_ctrl_pkg::*;
#(
    parameter int POWERUP_CYC  = 750000,
    parameter int CMD_CYC      = 2000,
    parameter int CLEAR_CYC    = 82000,
    parameter int EN_PULSE_CYC = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        show,
    input  logic        blank,
    input  logic [2:0]  opcode,
    input  logic [3:0]  reg_idx,
    input  logic [15:0] value,
    output logic        ready,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);

    localparam int PW = $clog2(POWERUP_CYC + 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYC - 1);

    ctrl_state_e   state;
    logic [PW-1:0] pcnt;
    logic [4:0]    idx;
    logic [4:0]    seq_len;
    logic [2:0]    op_q;
    logic [3:0]    reg_q;
    logic [15:0]   val_q;
    logic          bus_rs;
    logic [7:0]    bus_byte;
    logic          req;
    logic          ack;
    logic          done;

    assign lcd_rw = 1'b0;

    // byte to send next, selected by frame type and index
    always_comb begin
        seq_len  = 5'd0;
        bus_rs   = 1'b0;
        bus_byte = 8'h00;
        unique case (state)
            S_INIT: begin
                seq_len = INIT_LEN;
                unique case (idx[1:0])
                    2'd0:    bus_byte = LCD_FUNC_SET;
                    2'd1:    bus_byte = LCD_DISP_ON;
                    2'd2:    bus_byte = LCD_ENTRY;
                    default: bus_byte = LCD_CLEAR;
                endcase
            end
            S_SHOW: begin
                seq_len = SHOW_LEN;
                bus_rs  = 1'b1;
                unique case (idx[3:0])
                    4'd0: begin
                        bus_rs   = 1'b0;
                        bus_byte = LCD_CLEAR;
                    end
                    4'd1: begin
                        bus_rs   = 1'b0;
                        bus_byte = LCD_ROW1;
                    end
                    4'd2:  bus_byte = mnem_char(op_q, 2'd0);
                    4'd3:  bus_byte = mnem_char(op_q, 2'd1);
                    4'd4:  bus_byte = mnem_char(op_q, 2'd2);
                    4'd5:  bus_byte = mnem_char(op_q, 2'd3);
                    4'd6:  bus_byte = " ";
                    4'd7:  bus_byte = "R";
                    4'd8:  bus_byte = hex_ascii(reg_q);
                    4'd9: begin
                        bus_rs   = 1'b0;
                        bus_byte = LCD_ROW2;
                    end
                    4'd10: bus_byte = "0";
                    4'd11: bus_byte = "x";
                    4'd12: bus_byte = hex_ascii(val_q[15:12]);
                    4'd13: bus_byte = hex_ascii(val_q[11:8]);
                    4'd14: bus_byte = hex_ascii(val_q[7:4]);
                    default: bus_byte = hex_ascii(val_q[3:0]);
                endcase
            end
            S_BLANK: begin
                seq_len  = BLANK_LEN;
                bus_byte = LCD_CLEAR;
            end
            default: ;
        endcase
    end

    assign req = (state == S_INIT || state == S_SHOW ||
                  state == S_BLANK) && (idx < seq_len);

    lcd_byte_writer #(
        .CMD_CYC      (CMD_CYC),
        .CLEAR_CYC    (CLEAR_CYC),
        .EN_PULSE_CYC (EN_PULSE_CYC)
    ) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rs       (bus_rs),
        .din      (bus_byte),
        .ack      (ack),
        .done     (done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    // top sequencer: frame selection, byte index, ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PWRUP;
            pcnt  <= '0;
            idx   <= '0;
            ready <= 1'b0;
            op_q  <= '0;
            reg_q <= '0;
            val_q <= '0;
        end else begin
            unique case (state)
                S_PWRUP: begin
                    if (pcnt == PWR_LAST) begin
                        state <= S_INIT;
                        idx   <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (blank) begin
                        state <= S_BLANK;
                        idx   <= '0;
                        ready <= 1'b0;
                    end else if (show) begin
                        state <= S_SHOW;
                        idx   <= '0;
                        ready <= 1'b0;
                        op_q  <= opcode;
                        reg_q <= reg_idx;
                        val_q <= value;
                    end
                end
                default: begin
                    if (ack) begin
                        idx <= idx + 1'b1;
                    end
                    if (done && idx == seq_len) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
